fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares one synchronous FIFO write port among NREQ producers.
//  Round-robin arbitration picks at most one producer per cycle and steers its data onto the FIFO write port.
//  Never writes while the FIFO reports full.
//  Sits directly in front of the team's sync FIFO (wr/wdata/full interface).
// PARAMETERS
//  NREQ       4   number of requesters (>=2)
//  DWID       16  data width per requester, equals FIFO data width
//  BURST_LEN  4   max consecutive beats per grant (>=1); used only with FIFO_ARB_BURST_EN
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst           in   1          synchronous reset, active-high
//  req_i         in   NREQ       per-requester write request; data valid while high
//  wdata_i       in   NREQ*DWID  packed data, requester i at [i*DWID +: DWID]
//  gnt_o         out  NREQ       one-hot/zero accept; beat transferred when gnt_o[i]=1
//  fifo_wr_o     out  1          FIFO write strobe (= |gnt_o)
//  fifo_wdata_o  out  DWID       wdata_i slice of grantee; 0 when no grant
//  fifo_full_i   in   1          FIFO full flag
//  owner_o       out  $clog2(NREQ)  registered index of last granted requester
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): last_q=NREQ-1, state=ARB_IDLE, cnt=0, owner_o=NREQ-1.
//    gnt_o, fifo_wr_o and fifo_wdata_o are forced to 0 while rst=1.
//  - Grant, fifo_wr_o and fifo_wdata_o are combinational from req_i, fifo_full_i and state; zero added latency.
//    A beat is written in the same cycle it is granted.
//  - Requester holds req_i and data stable until granted; dropping req_i before grant is legal (request withdrawn).
//  - fifo_full_i=1: gnt_o=0, no state change (pointer, state, cnt hold).
//  - Round-robin: search starts at (last_q+1) mod NREQ, wraps.
//    On any grant, last_q and owner_o <= grantee next cycle.
//    After reset, requester 0 has top priority.
//  - req_i=0: gnt_o=0, state holds.
// CONFIGURATION
//  FIFO_ARB_BURST_EN undefined:
//    - Single state; every cycle re-arbitrates.
//    - Continuous requesters rotate one beat each.
//    - BURST_LEN ignored.
//  FIFO_ARB_BURST_EN defined: FSM ARB_IDLE / ARB_BURST.
//    - ARB_IDLE: RR grant to winner w.
//      If BURST_LEN>1, go to ARB_BURST with owner=w, cnt=1; else stay ARB_IDLE.
//    - ARB_BURST: only owner eligible; others get 0.
//      - Owner granted: cnt++. When cnt reaches BURST_LEN, go to ARB_IDLE, cnt=0.
//      - Owner req_i=0: no grant that cycle; go to ARB_IDLE, cnt=0.
//      - fifo_full_i=1: stay ARB_BURST, cnt holds.
//    - RR pointer always advances past the owner, so the next IDLE arbitration starts at owner+1.
// STRUCTURE
//  - fifo_arb_pkg:
//    - typedef enum logic {ARB_IDLE, ARB_BURST} arb_st_e
//    - localparam helpers for index width ($clog2(NREQ)) and counter width ($clog2(BURST_LEN+1))
//  - Sub-module rr_prio_pick: combinational, NREQ-bit req + start index -> one-hot grant + index.
//    Wrap by double-width mask.
//  - Top holds FSM, last_q, cnt, data mux.
// TESTING
//  1. rst=1 with req_i=4'b1111 -> gnt_o=0, fifo_wr_o=0.
//     After release, first grant=4'b0001, owner_o=0 next cycle.
//  2. Macro off, req_i=4'b1111, full=0 for 5 cycles -> gnt_o 0001,0010,0100,1000,0001.
//     fifo_wdata_o equals the matching slice each cycle.
//  3. req_i=4'b0101, full=1 for 3 cycles -> gnt_o=0, owner_o unchanged.
//     full drops -> gnt 0001 then 0100.
//  4. Macro on, BURST_LEN=4, req_i=4'b1111 -> gnt 0001 x4, then 0010 x4, then 0100 x4.
//  5. Macro on, BURST_LEN=4:
//     - Requester 0 drops req after 2 beats -> one cycle gnt=0, then 0010 bursts.
//     - Full asserted mid-burst -> burst resumes with cnt preserved.
//  6. Macro on, rst asserted mid-burst (cnt=2) -> state ARB_IDLE; after release, grant restarts at requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// The optional burst mode is selected by the FIFO_ARB_BURST_EN macro in fifo_wr_arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_st_e;

  // Index width for n requesters; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat-counter width able to hold the value len itself.
  function automatic int cnt_width(input int len);
    return (len > 0) ? $clog2(len + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating priority picker: first set request at or after start, wrapping.
// The wrap is done by shifting a doubled copy of the request vector.
module rr_prio_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW:0]       off;
  logic [IW:0]       sum;

  // Rotate so bit 0 is the start position, then take the lowest set bit.
  always_comb begin
    dbl   = {req, req} >> start;
    rot   = dbl[NREQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = (IW+1)'(k);
      end else begin
        off   = off;
      end
    end
    sum = {1'b0, start} + off;
    if (sum >= (IW+1)'(NREQ)) begin
      sum = sum - (IW+1)'(NREQ);
    end else begin
      sum = sum;
    end
    idx = sum[IW-1:0];
    gnt = '0;
    if (found) begin
      gnt[idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port among NREQ producers.
// Define FIFO_ARB_BURST_EN to let a winner keep the port for up to BURST_LEN beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWID      = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DWID-1:0]     wdata_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     fifo_wr_o,
  output logic [DWID-1:0]          fifo_wdata_o,
  input  logic                     fifo_full_i,
  output logic [$clog2(NREQ)-1:0]  owner_o
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = cnt_width(BURST_LEN);
`ifdef FIFO_ARB_BURST_EN
  localparam int BEATS = BURST_LEN;
`else
  localparam int BEATS = 1;
`endif
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(BEATS);

  logic [IW-1:0]   last_q;
  arb_st_e         state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   start_s;
  logic [IW-1:0]   pick_idx_s;
  logic [IW-1:0]   sel_s;
  logic [NREQ-1:0] pick_gnt_s;
  logic [NREQ-1:0] gnt_s;
  logic            pick_found_s;

  // Search begins just past the last grantee.
  always_comb begin
    if (last_q == LAST_IDX) begin
      start_s = '0;
    end else begin
      start_s = last_q + IW'(1);
    end
  end

  rr_prio_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req_i),
    .start (start_s),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Same-cycle grant; during a burst only the current owner may win.
  always_comb begin
    gnt_s = '0;
    sel_s = last_q;
    if (rst || fifo_full_i) begin
      gnt_s = '0;
    end else if (state == ARB_BURST) begin
      if (req_i[last_q]) begin
        gnt_s[last_q] = 1'b1;
      end else begin
        gnt_s = '0;
      end
    end else begin
      gnt_s = pick_gnt_s;
      sel_s = pick_idx_s;
    end
  end

  assign gnt_o        = gnt_s;
  assign fifo_wr_o    = |gnt_s;
  assign fifo_wdata_o = fifo_wr_o ? wdata_i[sel_s*DWID +: DWID] : '0;
  assign owner_o      = last_q;

  // Pointer, burst state and beat count; everything freezes while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LAST_IDX;
      state  <= ARB_IDLE;
      cnt    <= '0;
    end else if (fifo_full_i) begin
      last_q <= last_q;
      state  <= state;
      cnt    <= cnt;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found_s) begin
            last_q <= pick_idx_s;
            if (BEATS > 1) begin
              state <= ARB_BURST;
              cnt   <= CW'(1);
            end else begin
              state <= ARB_IDLE;
              cnt   <= '0;
            end
          end else begin
            last_q <= last_q;
          end
        end
        ARB_BURST: begin
          if (req_i[last_q] && ((cnt + CW'(1)) != CNT_END)) begin
            cnt <= cnt + CW'(1);
          end else begin
            state <= ARB_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed literal sequences plus a randomized run
// compared every cycle against a queue-free round-robin model; follows FIFO_ARB_BURST_EN.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
`ifdef FIFO_ARB_BURST_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] wdata_i;
  logic [N-1:0]    gnt_o;
  logic            fifo_wr_o;
  logic [DW-1:0]   fifo_wdata_o;
  logic            fifo_full_i;
  logic [1:0]      owner_o;

  fifo_wr_arbiter #(.NREQ(N), .DWID(DW), .BURST_LEN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .fifo_wr_o    (fifo_wr_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_full_i  (fifo_full_i),
    .owner_o      (owner_o)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nmis = 0;

  // Reference model: last granted index, beats already given in the current hold.
  int          m_last  = N - 1;
  int          m_beats = 0;
  bit          m_valid = 1'b0;
  int          m_win   = -1;
  logic [15:0] dat [N];
  bit          pend [N];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected winner for this cycle under the arbitration rules, -1 for none.
  function automatic int model_pick(input logic [N-1:0] r, input logic f, input logic rs);
    if (rs || f) return -1;
    if (m_beats > 0) return r[m_last] ? m_last : -1;
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic f, input logic rs);
    if (rs) begin
      m_last = N - 1; m_beats = 0; m_valid = 1'b1;
    end else if (!f) begin
      if (m_beats > 0) begin
        if (r[m_last]) begin
          m_beats++;
          if (m_beats == BL) m_beats = 0;
        end else begin
          m_beats = 0;
        end
      end else if (m_win >= 0) begin
        m_last = m_win;
        m_beats = (BL > 1) ? 1 : 0;
      end
    end
  endtask

  // One clock: drive, sample at negedge, compare, advance model.
  task automatic step(input logic [N-1:0] r, input logic f, input logic rs,
                      input bit lit_en, input logic [N-1:0] lit);
    int exp_g;
    int exp_d;
    req_i = r; fifo_full_i = f; rst = rs;
    for (int i = 0; i < N; i++) wdata_i[i*DW +: DW] = dat[i];
    @(negedge clk);
    m_win = model_pick(r, f, rs);
    exp_g = (m_win >= 0) ? (1 << m_win) : 0;
    exp_d = (m_win >= 0) ? int'(dat[m_win]) : 0;
    chk("gnt", int'(gnt_o), exp_g);
    chk("fifo_wr", int'(fifo_wr_o), (m_win >= 0) ? 1 : 0);
    chk("fifo_wdata", int'(fifo_wdata_o), exp_d);
    if (m_valid) chk("owner", int'(owner_o), m_last);
    if (lit_en) chk("gnt_literal", int'(gnt_o), int'(lit));
    model_update(r, f, rs);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] seq2 [5];
    logic [N-1:0] r;
    logic         f;
    logic         rs;
    for (int i = 0; i < N; i++) dat[i] = 16'h1000 * 16'(i + 1) + 16'h00A5;
    seq2[0] = 4'b0001; seq2[1] = 4'b0010; seq2[2] = 4'b0100; seq2[3] = 4'b1000; seq2[4] = 4'b0001;

    // Reset with every requester active: nothing may be granted.
    step(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000);
    step(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000);
    chk("owner_reset", int'(owner_o), 3);

`ifdef FIFO_ARB_BURST_EN
    for (int i = 0; i < 12; i++) step(4'b1111, 1'b0, 1'b0, 1'b1, 4'(1 << (i / 4)));
    // Owner 0 withdraws after two beats: one idle cycle, then requester 1 bursts.
    step(4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000);
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
    step(4'b1110, 1'b0, 1'b0, 1'b1, 4'b0000);
    step(4'b1110, 1'b0, 1'b0, 1'b1, 4'b0010);
    step(4'b1110, 1'b0, 1'b1, 1'b1, 4'b0000);
    // Full mid-burst freezes the count; the remaining beats still follow.
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
    step(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000);
    step(4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000);
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0010);
    // Reset in the middle of that burst restarts at requester 0.
    step(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000);
    step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
`else
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 1'b0, 1'b1, seq2[i]);
      if (i == 0) chk("owner_first", int'(owner_o), 0);
    end
    step(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) step(4'b0101, 1'b1, 1'b0, 1'b1, 4'b0000);
    chk("owner_hold_full", int'(owner_o), 3);
    step(4'b0101, 1'b0, 1'b0, 1'b1, 4'b0001);
    step(4'b0101, 1'b0, 1'b0, 1'b1, 4'b0100);
    chk("owner_after", int'(owner_o), 2);
`endif

    // Randomized traffic: data held while pending, occasional withdrawal, full and reset.
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          dat[i] = 16'($urandom);
        end else if (pend[i] && ($urandom_range(15, 0) == 0)) begin
          pend[i] = 1'b0;
        end
        r[i] = pend[i];
      end
      f  = ($urandom_range(4, 0) == 0);
      rs = ($urandom_range(99, 0) == 0);
      step(r, f, rs, 1'b0, 4'b0000);
      if (m_win >= 0) pend[m_win] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
